// File: rtl/pic_timer_pkg.sv
// Shared constants for the pic_timer_n peripheral: register map, CTRL/STAT bit positions and
// reset values, plus a byte-lane write helper.
package pic_timer_pkg;

    localparam logic [3:0] AddrCtrl = 4'd0;
    localparam logic [3:0] AddrStat = 4'd1;
    localparam logic [3:0] AddrCntL = 4'd2;
    localparam logic [3:0] AddrCntH = 4'd3;
    localparam logic [3:0] AddrPerL = 4'd4;
    localparam logic [3:0] AddrPerH = 4'd5;
    localparam logic [3:0] AddrCmpL = 4'd6;
    localparam logic [3:0] AddrCmpH = 4'd7;
    localparam logic [3:0] AddrCapL = 4'd8;
    localparam logic [3:0] AddrCapH = 4'd9;

    localparam int unsigned CtrlEn    = 0;
    localparam int unsigned CtrlSrc   = 1;
    localparam int unsigned CtrlEdge  = 2;
    localparam int unsigned CtrlPsLsb = 3;
    localparam int unsigned CtrlArl   = 6;
    localparam int unsigned CtrlIe    = 7;

    localparam int unsigned StatOvf  = 0;
    localparam int unsigned StatCmpf = 1;
    localparam int unsigned StatCapf = 2;

    localparam logic [15:0] PerRst = 16'hFFFF;

    function automatic logic [15:0] wr_byte(input logic [15:0] cur, input logic hi,
                                            input logic [7:0] d);
        return hi ? {d, cur[7:0]} : {cur[15:8], d};
    endfunction

endpackage

// File: rtl/pic_edge_sync.sv
// Two-flop synchroniser followed by a rising/falling edge detector; emits a one-cycle pulse
// two clocks after the input edge, so a consumer acts on the third clock.
module pic_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    input  logic fall_i,
    output logic pulse_o
);

    // [0],[1] synchronise; [2] holds the previous synchronised value
    logic [2:0] sh_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sh_q <= 3'b000;
        end else begin
            sh_q <= {sh_q[1:0], d_i};
        end
    end

    always_comb begin
        pulse_o = fall_i ? (sh_q[2] & ~sh_q[1]) : (sh_q[1] & ~sh_q[2]);
    end

endmodule

// File: rtl/pic_timer_n.sv
// WIDTH-bit timer/counter with prescaler, compare/PWM and IRQ on a byte-wide register port.
// Optional input capture is built only when PIC_TMR_CAPTURE_EN is defined.
module pic_timer_n
    import pic_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned PS_W  = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       WE,
    input  logic [3:0] ADDR,
    input  logic [7:0] WDATA,
    output logic [7:0] RDATA,
    input  logic       T_IN,
    input  logic       CAP_IN,
    output logic       PWM_OUT,
    output logic       IRQ
);

    localparam int unsigned PscW = (32'd1 << PS_W) - 32'd1;

    logic [7:0]       ctrl_q, ctrl_d;
    logic [2:0]       stat_q, stat_d, stat_set, stat_clr;
    logic [WIDTH-1:0] cnt_q, cnt_d, per_q, per_d, cmp_q, cmp_d;
    logic [PscW-1:0]  psc_q, psc_d, psc_max;
    logic             pwm_q, irq_q;
    logic             t_pulse, src_tick, cnt_tick, cnt_wr;
    logic [PS_W-1:0]  ps;
    logic [15:0]      cnt16, per16, cmp16, cap16;

    pic_edge_sync u_t_sync (
        .clk_i   (CLK),
        .rst_i   (RST),
        .d_i     (T_IN),
        .fall_i  (ctrl_q[CtrlEdge]),
        .pulse_o (t_pulse)
    );

`ifdef PIC_TMR_CAPTURE_EN
    logic             cap_pulse;
    logic [WIDTH-1:0] cap_q;

    pic_edge_sync u_cap_sync (
        .clk_i   (CLK),
        .rst_i   (RST),
        .d_i     (CAP_IN),
        .fall_i  (1'b0),
        .pulse_o (cap_pulse)
    );

    // Capture samples CNT before any same-cycle update
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cap_q <= '0;
        end else if (cap_pulse) begin
            cap_q <= cnt_q;
        end
    end

    assign cap16 = 16'(cap_q);
`else
    logic unused_cap;
    assign unused_cap = CAP_IN;
    assign cap16      = 16'h0000;
`endif

    assign ps       = PS_W'(ctrl_q[CtrlPsLsb +: 3]);
    assign psc_max  = PscW'((32'd1 << ps) - 32'd1);
    assign src_tick = ctrl_q[CtrlSrc] ? t_pulse : 1'b1;
    assign cnt_tick = ctrl_q[CtrlEn] & src_tick & (psc_q == psc_max);
    assign cnt_wr   = WE & ((ADDR == AddrCntL) | (ADDR == AddrCntH));
    assign cnt16    = 16'(cnt_q);
    assign per16    = 16'(per_q);
    assign cmp16    = 16'(cmp_q);

    always_comb begin
        ctrl_d   = ctrl_q;
        cnt_d    = cnt_q;
        per_d    = per_q;
        cmp_d    = cmp_q;
        psc_d    = psc_q;
        stat_set = 3'b000;
        stat_clr = 3'b000;

        if (ctrl_q[CtrlEn] && src_tick) begin
            psc_d = (psc_q == psc_max) ? '0 : psc_q + 1'b1;
        end

        // A CNT write wins outright over a same-cycle count tick
        if (cnt_tick && !cnt_wr) begin
            if (cnt_q == per_q) begin
                cnt_d             = '0;
                stat_set[StatOvf] = 1'b1;
                if (!ctrl_q[CtrlArl]) begin
                    ctrl_d[CtrlEn] = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_d == cmp_q) begin
                stat_set[StatCmpf] = 1'b1;
            end
        end

`ifdef PIC_TMR_CAPTURE_EN
        stat_set[StatCapf] = cap_pulse;
`endif

        if (WE) begin
            case (ADDR)
                AddrCtrl: ctrl_d = WDATA;
                AddrStat: stat_clr = WDATA[2:0];
                AddrCntL, AddrCntH: begin
                    cnt_d = WIDTH'(wr_byte(cnt16, ADDR == AddrCntH, WDATA));
                    psc_d = '0;
                end
                AddrPerL, AddrPerH: per_d = WIDTH'(wr_byte(per16, ADDR == AddrPerH, WDATA));
                AddrCmpL, AddrCmpH: cmp_d = WIDTH'(wr_byte(cmp16, ADDR == AddrCmpH, WDATA));
                default: ;
            endcase
        end

        stat_d = (stat_q & ~stat_clr) | stat_set;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ctrl_q <= 8'h00;
            stat_q <= 3'b000;
            cnt_q  <= '0;
            per_q  <= WIDTH'(PerRst);
            cmp_q  <= '0;
            psc_q  <= '0;
            pwm_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            stat_q <= stat_d;
            cnt_q  <= cnt_d;
            per_q  <= per_d;
            cmp_q  <= cmp_d;
            psc_q  <= psc_d;
            pwm_q  <= ctrl_q[CtrlEn] & (cnt_q < cmp_q);
            irq_q  <= ctrl_q[CtrlIe] & (|stat_q);
        end
    end

    always_comb begin
        RDATA = 8'h00;
        case (ADDR)
            AddrCtrl: RDATA = ctrl_q;
            AddrStat: RDATA = {5'b00000, stat_q};
            AddrCntL: RDATA = cnt16[7:0];
            AddrCntH: RDATA = cnt16[15:8];
            AddrPerL: RDATA = per16[7:0];
            AddrPerH: RDATA = per16[15:8];
            AddrCmpL: RDATA = cmp16[7:0];
            AddrCmpH: RDATA = cmp16[15:8];
            AddrCapL: RDATA = cap16[7:0];
            AddrCapH: RDATA = cap16[15:8];
            default:  RDATA = 8'h00;
        endcase
    end

    assign PWM_OUT = pwm_q;
    assign IRQ     = irq_q;

endmodule

// File: tb/tb_pic_timer_n.sv
// Directed and randomized checks of pic_timer_n against closed-form expectations derived from
// tick counts; capture checks depend on PIC_TMR_CAPTURE_EN.
module tb_pic_timer_n;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       WE = 1'b0;
    logic [3:0] ADDR = 4'd0;
    logic [7:0] WDATA = 8'd0;
    logic [7:0] RDATA;
    logic       T_IN = 1'b0;
    logic       CAP_IN = 1'b0;
    logic       PWM_OUT;
    logic       IRQ;

    int total = 0;
    int bad = 0;

    pic_timer_n #(.WIDTH(16), .PS_W(3)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .WE      (WE),
        .ADDR    (ADDR),
        .WDATA   (WDATA),
        .RDATA   (RDATA),
        .T_IN    (T_IN),
        .CAP_IN  (CAP_IN),
        .PWM_OUT (PWM_OUT),
        .IRQ     (IRQ)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1 with the write committed
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        WE = 1'b1;
        ADDR = a;
        WDATA = d;
        @(posedge CLK);
        #1;
        WE = 1'b0;
    endtask

    task automatic wr16(input logic [3:0] a, input logic [15:0] d);
        wr(a, d[7:0]);
        wr(a + 4'd1, d[15:8]);
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        ADDR = a;
        #1;
        d = RDATA;
    endtask

    task automatic rd16(input logic [3:0] a, output logic [15:0] d);
        logic [7:0] lo, hi;
        rd(a, lo);
        rd(a + 4'd1, hi);
        d = {hi, lo};
    endtask

    task automatic clk(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic stop_and_setup(input logic [15:0] per, input logic [15:0] cmp,
                                  input logic [15:0] cnt);
        wr(4'd0, 8'h00);
        wr16(4'd4, per);
        wr16(4'd6, cmp);
        wr16(4'd2, cnt);
        wr(4'd1, 8'h07);
    endtask

    initial begin
        logic [7:0]  b;
        logic [15:0] w;
        int          pwm_hi;

        // 1: reset state
        clk(2);
        RST = 1'b0;
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), b);
            check($sformatf("reset_reg%0d", a), {8'h00, b},
                  (a == 4 || a == 5) ? 16'h00FF : 16'h0000);
        end
        check("reset_pwm", {15'd0, PWM_OUT}, 16'd0);
        check("reset_irq", {15'd0, IRQ}, 16'd0);

        // 2: auto-reload overflow, IRQ latency, W1C
        stop_and_setup(16'd9, 16'hFFFF, 16'd0);
        wr(4'd0, 8'hC1);
        clk(9);
        rd16(4'd2, w);
        check("t2_cnt9", w, 16'd9);
        rd(4'd1, b);
        check("t2_stat_before", {8'h00, b}, 16'd0);
        clk(1);
        rd16(4'd2, w);
        check("t2_cnt_wrap", w, 16'd0);
        rd(4'd1, b);
        check("t2_ovf", {8'h00, b}, 16'd1);
        check("t2_irq_lag", {15'd0, IRQ}, 16'd0);
        clk(1);
        check("t2_irq", {15'd0, IRQ}, 16'd1);
        wr(4'd1, 8'h01);
        rd(4'd1, b);
        check("t2_w1c", {8'h00, b}, 16'd0);
        clk(1);
        check("t2_irq_clr", {15'd0, IRQ}, 16'd0);

        // 3: one-shot with PS=2
        stop_and_setup(16'd3, 16'hFFFF, 16'd0);
        wr(4'd0, 8'h11);
        clk(3);
        rd16(4'd2, w);
        check("t3_cnt_e3", w, 16'd0);
        clk(1);
        rd16(4'd2, w);
        check("t3_cnt_e4", w, 16'd1);
        clk(11);
        rd16(4'd2, w);
        check("t3_cnt_e15", w, 16'd3);
        clk(1);
        rd16(4'd2, w);
        check("t3_cnt_e16", w, 16'd0);
        rd(4'd1, b);
        check("t3_ovf", {8'h00, b}, 16'd1);
        rd(4'd0, b);
        check("t3_ctrl_en_off", {8'h00, b}, 16'h0010);
        clk(8);
        rd16(4'd2, w);
        check("t3_cnt_hold", w, 16'd0);

        // 4: external source, falling edges
        stop_and_setup(16'hFFFF, 16'hFFFF, 16'd0);
        T_IN = 1'b1;
        clk(4);
        wr(4'd0, 8'h07);
        for (int i = 0; i < 5; i++) begin
            T_IN = 1'b0;
            clk(2);
            rd16(4'd2, w);
            check($sformatf("t4_pre%0d", i), w, 16'(i));
            clk(1);
            rd16(4'd2, w);
            check($sformatf("t4_post%0d", i), w, 16'(i + 1));
            T_IN = 1'b1;
            clk(4);
            rd16(4'd2, w);
            check($sformatf("t4_rise%0d", i), w, 16'(i + 1));
        end

        // 5: PWM duty and CNT write priority
        stop_and_setup(16'd9, 16'd4, 16'd0);
        wr(4'd0, 8'h41);
        clk(12);
        pwm_hi = 0;
        for (int i = 0; i < 20; i++) begin
            pwm_hi += int'(PWM_OUT);
            clk(1);
        end
        check("t5_pwm_duty", 16'(pwm_hi), 16'd8);
        wr(4'd2, 8'h07);
        rd16(4'd2, w);
        check("t5_cnt_write", w, 16'd7);

        // Randomized: ARL=1, SRC=0, run k clocks then freeze and compare to tick arithmetic
        for (int it = 0; it < 10; it++) begin
            int per, cmp, ps, k, ticks, ecnt;
            logic eovf, ecmpf;
            per = $urandom_range(0, 40);
            cmp = $urandom_range(0, 45);
            ps = $urandom_range(0, 3);
            k = $urandom_range(1, 150);
            stop_and_setup(16'(per), 16'(cmp), 16'd0);
            wr(4'd0, 8'hC1 | 8'(ps << 3));
            clk(k - 1);
            wr(4'd0, 8'hC0 | 8'(ps << 3));
            ticks = k >> ps;
            ecnt = ticks % (per + 1);
            eovf = ticks >= per + 1;
            ecmpf = (cmp == 0) ? (ticks >= per + 1) : (cmp <= per && ticks >= cmp);
            rd16(4'd2, w);
            check($sformatf("rnd%0d_cnt", it), w, 16'(ecnt));
            rd(4'd1, b);
            check($sformatf("rnd%0d_stat", it), {8'h00, b}, {14'd0, ecmpf, eovf});
            clk(1);
            check($sformatf("rnd%0d_irq", it), {15'd0, IRQ}, {15'd0, eovf | ecmpf});
        end

`ifdef PIC_TMR_CAPTURE_EN
        // 6: capture, then same-cycle set vs W1C
        stop_and_setup(16'hFFFF, 16'hFFFF, 16'h0123);
        CAP_IN = 1'b0;
        clk(4);
        CAP_IN = 1'b1;
        clk(3);
        rd16(4'd8, w);
        check("t6_cap", w, 16'h0123);
        rd(4'd1, b);
        check("t6_capf", {8'h00, b}, 16'h0004);
        CAP_IN = 1'b0;
        clk(4);
        CAP_IN = 1'b1;
        clk(2);
        wr(4'd1, 8'h04);
        rd(4'd1, b);
        check("t6_set_wins", {8'h00, b}, 16'h0004);
        wr(4'd1, 8'h04);
        rd(4'd1, b);
        check("t6_w1c", {8'h00, b}, 16'h0000);
`else
        // Capture absent: CAP_IN has no effect
        stop_and_setup(16'hFFFF, 16'hFFFF, 16'h0123);
        CAP_IN = 1'b1;
        clk(5);
        CAP_IN = 1'b0;
        clk(5);
        rd16(4'd8, w);
        check("nocap_cap", w, 16'h0000);
        rd(4'd1, b);
        check("nocap_stat", {8'h00, b}, 16'h0000);
`endif

        // Reset mid-count with IRQ and PWM active
        stop_and_setup(16'd2, 16'd1, 16'd0);
        wr(4'd0, 8'hC1);
        clk(10);
        check("pre_rst_irq", {15'd0, IRQ}, 16'd1);
        RST = 1'b1;
        #1;
        check("rst_irq", {15'd0, IRQ}, 16'd0);
        check("rst_pwm", {15'd0, PWM_OUT}, 16'd0);
        rd16(4'd2, w);
        check("rst_cnt", w, 16'd0);
        rd16(4'd4, w);
        check("rst_per", w, 16'hFFFF);
        rd(4'd0, b);
        check("rst_ctrl", {8'h00, b}, 16'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pic_timer_n.md
Name: pic_timer_n

Overview:
Parametrised general-purpose timer/counter peripheral for the PIC16-class core, the next generation of the fixed 8-bit TMR0 block.
- WIDTH-bit counter with a programmable period (auto-reload or one-shot) and an internal or external synchronised clock source.
- Power-of-two prescaler, compare flag with PWM output, and an interrupt request.
- Attaches to the core's special-function-register write/read path through a byte-wide register port.

Parameters:
WIDTH, 16, counter/period/compare width in bits; legal range 8..16.
PS_W, 3, prescaler select width; division 2^PS for PS in 0..2^PS_W-1.

Ports:
CLK  input  1  system clock; all state on rising edge.
RST  input  1  reset, asynchronous, active-high.
WE  input  1  register write strobe.
ADDR  input  4  register address.
WDATA  input  8  write data.
RDATA  output  8  read data, combinational from ADDR.
T_IN  input  1  external count input, asynchronous.
CAP_IN  input  1  capture trigger, asynchronous; used only with PIC_TMR_CAPTURE_EN.
PWM_OUT  output  1  registered PWM output.
IRQ  output  1  interrupt request, level.

Behaviour:
- Register map:
  - 0 CTRL: [0]EN, [1]SRC (0 = CLK, 1 = T_IN), [2]EDGE (0 = rising, 1 = falling), [5:3]PS, [6]ARL (1 = auto-reload), [7]IE.
  - 1 STAT: [0]OVF, [1]CMPF, [2]CAPF; write-1-to-clear.
  - 2/3 CNT L/H, 4/5 PER L/H, 6/7 CMP L/H, 8/9 CAP L/H (read-only). Others read 0.
- Bits above WIDTH read 0 and ignore writes.
- Reset values: CTRL=0, CNT=0, PER=all ones, CMP=0, STAT=0, CAP=0, prescaler=0, PWM_OUT=0, IRQ=0.
- External source: T_IN passes a 2-FF synchroniser, then an edge detector selected by EDGE. A source tick occurs 3 CLK after the T_IN edge. With SRC=0, every CLK is a source tick.
- Prescaler:
  - Counts source ticks only while EN=1.
  - PS=0: every source tick is a count tick.
  - Otherwise, a count tick is issued when the prescaler reaches 2^PS-1; the prescaler then returns to 0.
- Counter, on a count tick:
  - If CNT==PER: CNT<=0 and OVF<=1. If ARL=0, EN<=0 in the same cycle (one-shot; CNT stays 0).
  - Otherwise CNT<=CNT+1.
- PER=0: CNT holds 0 and OVF is set every count tick.
- Compare: CMPF<=1 on the count tick whose next CNT equals CMP.
- PWM_OUT: registered, PWM_OUT<=EN & (CNT<CMP).
  - CMP=0 gives constant 0.
  - CMP>PER gives constant 1 while enabled.
- Writes:
  - A write to CNT L/H loads that byte and clears the prescaler. Write wins over a same-cycle count tick.
  - A write to CTRL takes effect next cycle. Clearing EN freezes CNT and the prescaler.
- STAT: a hardware set and a same-cycle W1C clear of the same bit resolves to set.
- IRQ = IE & (OVF|CMPF|CAPF), registered (1 CLK after the flag is set).
- RST asserted mid-count returns all state to reset values immediately. The synchroniser flops also reset to 0.

Optional Feature:
Macro PIC_TMR_CAPTURE_EN.
- Defined:
  - CAP_IN passes the same synchroniser/edge detector, on rising edges only.
  - On a detected edge, CAP<=CNT (value before any same-cycle update) and CAPF<=1.
  - A second edge before CAPF is cleared overwrites CAP.
- Undefined: CAP_IN is ignored, CAP reads 0, CAPF stays 0, and no capture logic is synthesised.

Decomposition:
- Package pic_timer_pkg: register address constants, CTRL/STAT bit index constants, reset value of PER.
- One sub-module, pic_edge_sync (2-FF synchroniser + selectable edge detect, 1-cycle pulse out). Instantiated for T_IN and, when enabled, CAP_IN.

Test Plan:
1. Reset, then read all registers: PER=0xFFFF, others 0, PWM_OUT=0, IRQ=0.
2. PER=9, PS=0, ARL=1, IE=1, EN=1, SRC=0: OVF sets on the 10th clock after enable, CNT=0; IRQ asserts one clock later. W1C STAT=0x01 clears OVF and IRQ.
3. PS=2, ARL=0, PER=3: CNT increments every 4 clocks; OVF after 16 clocks, EN reads 0, CNT holds 0.
4. SRC=1, EDGE=1, 5 falling T_IN edges: CNT=5, each increment 3 clocks after its edge; rising edges do not count.
5. PER=9, CMP=4: PWM_OUT high for 4 of every 10 clocks. Writing CNT_L=7 on the same cycle as a tick gives CNT=7.
6. With PIC_TMR_CAPTURE_EN and CAP_IN rising at CNT=0x0123: CAP=0x0123, CAPF=1. Same-cycle hardware set and W1C clear leave CAPF=1.
